// File: rtl/axi_bank_ctrl.sv
// Single-outstanding AXI-lite style front end for a 4 KiB row-organised bank.
// Writes and reads are arbitrated in IDLE and sequenced through a small FSM.
module axi_bank_ctrl #(
  parameter int SIZE = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [11:0]               awaddr,
  input  logic                      wvalid,
  output logic                      wready,
  input  logic [(2**SIZE)*8-1:0]    wdata,
  input  logic [(2**SIZE)-1:0]      wstrb,
  output logic                      bvalid,
  input  logic                      bready,
  output logic [1:0]                bresp,
  input  logic                      arvalid,
  output logic                      arready,
  input  logic [11:0]               araddr,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [(2**SIZE)*8-1:0]    rdata,
  output logic [1:0]                rresp,
  output logic                      bank_we,
  output logic [11-SIZE:0]          bank_row_addr,
  output logic [(2**SIZE)*8-1:0]    bank_wdata,
  output logic [(2**SIZE)-1:0]      bank_wstrb,
  input  logic [(2**SIZE)*8-1:0]    bank_rdata
);

  localparam int SW = 2**SIZE;
  localparam int DW = SW * 8;
  localparam int RW = 12 - SIZE;

  typedef enum logic [2:0] {
    IDLE,
    WR_BANK,
    WR_RESP,
    RD_ADDR,
    RD_CAP,
    RD_RESP
  } state_t;

  state_t          state_reg, state_next;
  logic            last_wr_reg, last_wr_next;
  logic [RW-1:0]   row_reg;
  logic [DW-1:0]   wdata_reg;
  logic [SW-1:0]   wstrb_reg;
  logic [DW-1:0]   rdata_reg;

  logic            wr_pend, rd_pend;
  logic            grant_wr, grant_rd;
  logic            unused_low_bits;

  // Byte offset within a row carries no meaning for a whole-row bank.
  assign unused_low_bits = ^{awaddr[SIZE-1:0], araddr[SIZE-1:0]};

  assign wr_pend = awvalid && wvalid;
  assign rd_pend = arvalid;

  // Under contention the side that did not win last time gets the grant.
  assign grant_wr = !rst && (state_reg == IDLE) && wr_pend && (!rd_pend || !last_wr_reg);
  assign grant_rd = !rst && (state_reg == IDLE) && rd_pend && (!wr_pend || last_wr_reg);

  assign awready = grant_wr;
  assign wready  = grant_wr;
  assign arready = grant_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      last_wr_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      last_wr_reg <= last_wr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    last_wr_next = last_wr_reg;
    case (state_reg)
      IDLE: begin
        if (grant_wr) begin
          state_next   = WR_BANK;
          last_wr_next = 1'b1;
        end else if (grant_rd) begin
          state_next   = RD_ADDR;
          last_wr_next = 1'b0;
        end
      end
      WR_BANK: state_next = WR_RESP;
      WR_RESP: if (bready) state_next = IDLE;
      RD_ADDR: state_next = RD_CAP;
      RD_CAP:  state_next = RD_RESP;
      RD_RESP: if (rready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_reg   <= '0;
      wdata_reg <= '0;
      wstrb_reg <= '0;
      rdata_reg <= '0;
    end else begin
      if (grant_wr) begin
        row_reg   <= awaddr[11:SIZE];
        wdata_reg <= wdata;
        wstrb_reg <= wstrb;
      end else if (grant_rd) begin
        row_reg <= araddr[11:SIZE];
      end
      // The bank registers its output, so data for RD_ADDR's row lands here.
      if (state_reg == RD_CAP) begin
        rdata_reg <= bank_rdata;
      end
    end
  end

  // Reset gating keeps the bank untouched even if rst hits during WR_BANK.
  assign bank_we       = !rst && (state_reg == WR_BANK);
  assign bank_row_addr = rst ? '0 : row_reg;
  assign bank_wdata    = wdata_reg;

  genvar gi;
  generate
    for (gi = 0; gi < SW; gi++) begin : g_strb
      assign bank_wstrb[gi] = bank_we & wstrb_reg[gi];
    end
  endgenerate

  assign bvalid = !rst && (state_reg == WR_RESP);
  assign rvalid = !rst && (state_reg == RD_RESP);
  assign rdata  = rst ? '0 : rdata_reg;
  assign bresp  = 2'b00;
  assign rresp  = 2'b00;

endmodule

// File: tb/tb_axi_bank_ctrl.sv
// Randomised scoreboard bench for axi_bank_ctrl (SIZE=2) with a behavioural bank
// and an independent row-array reference model.
module tb_axi_bank_ctrl;
  localparam int SIZE  = 2;
  localparam int NROWS = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [11:0] awaddr, araddr;
  logic [31:0] wdata, rdata, bank_wdata, bank_rdata;
  logic [3:0]  wstrb, bank_wstrb;
  logic [1:0]  bresp, rresp;
  logic        bank_we;
  logic [9:0]  bank_row_addr;

  int errors = 0;
  int checks = 0;

  logic [31:0] ref_mem [NROWS];
  logic [1:0]  exp_bq [$];
  logic [31:0] exp_rq [$];

  always #5 clk = ~clk;

  axi_bank_ctrl #(.SIZE(SIZE)) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .bank_we(bank_we), .bank_row_addr(bank_row_addr), .bank_wdata(bank_wdata),
    .bank_wstrb(bank_wstrb), .bank_rdata(bank_rdata)
  );

  // Behavioural bank: byte writes follow the strobe alone, registered read.
  logic [31:0] bmem [NROWS];
  logic        mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < NROWS; i++) bmem[i] <= 32'h0;
      mem_ready  <= 1'b1;
      bank_rdata <= 32'h0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (bank_wstrb[b]) bmem[bank_row_addr][8*b +: 8] <= bank_wdata[8*b +: 8];
      bank_rdata <= bmem[bank_row_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s at %0t", name, what, $time);
  endtask

  // Monitor: pops the scoreboard whenever a response handshake completes.
  always @(negedge clk) begin
    if (bvalid && bready) begin
      if (exp_bq.size() == 0) fail("b_unexpected", "B handshake with nothing outstanding");
      else check("bresp", {30'h0, bresp}, {30'h0, exp_bq.pop_front()});
    end
    if (rvalid && rready) begin
      if (exp_rq.size() == 0) fail("r_unexpected", "R handshake with nothing outstanding");
      else begin
        check("rdata", rdata, exp_rq.pop_front());
        check("rresp", {30'h0, rresp}, 32'h0);
      end
    end
  end

  task automatic ref_write(input logic [9:0] row, input logic [31:0] data, input logic [3:0] strb);
    for (int b = 0; b < 4; b++)
      if (strb[b]) ref_mem[row][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic wait_grant(input bit is_wr, output bit ok);
    int n = 0;
    @(negedge clk);
    while (!(is_wr ? awready : arready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = is_wr ? awready : arready;
  endtask

  task automatic do_write(input logic [11:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int bdelay);
    logic [9:0] row;
    bit ok;
    row = addr[11:2];
    @(posedge clk); #1;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    wait_grant(1'b1, ok);
    if (!ok) begin
      fail("aw_timeout", "awready never asserted");
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    check("wready_with_awready", {31'h0, wready}, 32'h1);
    ref_write(row, data, strb);
    exp_bq.push_back(2'b00);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = (bdelay == 0);
    @(negedge clk);
    check("wr_bank_we", {31'h0, bank_we}, 32'h1);
    check("wr_bank_row", {22'h0, bank_row_addr}, {22'h0, row});
    check("wr_bank_strb", {28'h0, bank_wstrb}, {28'h0, strb});
    check("wr_bank_data", bank_wdata, data);
    check("wr_bvalid_early", {31'h0, bvalid}, 32'h0);
    @(negedge clk);
    check("wr_bvalid", {31'h0, bvalid}, 32'h1);
    check("wr_we_off", {31'h0, bank_we}, 32'h0);
    if (bdelay > 0) begin
      @(posedge clk); #1;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      repeat (bdelay - 1) begin
        @(negedge clk);
        check("bstall_bvalid", {31'h0, bvalid}, 32'h1);
        check("bstall_strb", {28'h0, bank_wstrb}, 32'h0);
        check("bstall_ready", {30'h0, awready, arready}, 32'h0);
      end
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] addr, input int rdelay);
    logic [9:0]  row;
    logic [31:0] first;
    bit ok;
    row = addr[11:2];
    @(posedge clk); #1;
    araddr = addr; arvalid = 1'b1;
    wait_grant(1'b0, ok);
    if (!ok) begin
      fail("ar_timeout", "arready never asserted");
      arvalid = 1'b0;
      return;
    end
    exp_rq.push_back(ref_mem[row]);
    @(posedge clk); #1;
    arvalid = 1'b0; rready = (rdelay == 0);
    @(negedge clk);
    check("rd_addr_row", {22'h0, bank_row_addr}, {22'h0, row});
    check("rd_rvalid_t1", {31'h0, rvalid}, 32'h0);
    @(negedge clk);
    check("rd_rvalid_t2", {31'h0, rvalid}, 32'h0);
    @(negedge clk);
    check("rd_rvalid_t3", {31'h0, rvalid}, 32'h1);
    first = rdata;
    if (rdelay > 0) begin
      @(posedge clk); #1;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      repeat (rdelay - 1) begin
        @(negedge clk);
        check("rstall_rvalid", {31'h0, rvalid}, 32'h1);
        check("rstall_rdata", rdata, first);
        check("rstall_ready", {30'h0, awready, arready}, 32'h0);
      end
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; rready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic half_valid();
    @(posedge clk); #1;
    awvalid = 1'b1; wvalid = 1'b0;
    @(negedge clk);
    check("aw_only_ready", {29'h0, awready, wready, arready}, 32'h0);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b1;
    @(negedge clk);
    check("w_only_ready", {29'h0, awready, wready, arready}, 32'h0);
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic abort_write(input logic [11:0] addr, input logic [31:0] data);
    bit ok;
    @(posedge clk); #1;
    awaddr = addr; wdata = data; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    wait_grant(1'b1, ok);
    if (!ok) fail("abort_aw_timeout", "awready never asserted");
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; rst = 1'b1; bready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("abort_w_we", {27'h0, bank_we, bank_wstrb}, 32'h0);
      check("abort_w_bvalid", {31'h0, bvalid}, 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_w_post", {30'h0, bvalid, bank_we}, 32'h0);
    end
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic abort_read(input logic [11:0] addr);
    bit ok;
    @(posedge clk); #1;
    araddr = addr; arvalid = 1'b1;
    wait_grant(1'b0, ok);
    if (!ok) fail("abort_ar_timeout", "arready never asserted");
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_r_rvalid", {31'h0, rvalid}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("abort_r_post", {31'h0, rvalid}, 32'h0);
    end
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit          gseq [$];
    int          gcyc [$];
    int          ecyc;
    logic [9:0]  rows [4];
    logic [9:0]  row;
    logic [11:0] a;

    rows[0] = 10'd0; rows[1] = 10'd4; rows[2] = 10'd5; rows[3] = 10'd1023;
    for (int i = 0; i < NROWS; i++) ref_mem[i] = 32'h0;
    rst = 1'b1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;

    // Reset state with every request line asserted.
    repeat (2) @(posedge clk);
    #1; awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_readies", {29'h0, awready, wready, arready}, 32'h0);
      check("rst_valids", {30'h0, bvalid, rvalid}, 32'h0);
      check("rst_bank", {17'h0, bank_we, bank_wstrb, bank_row_addr}, 32'h0);
      check("rst_rdata", rdata, 32'h0);
    end

    // Continuous contention straight out of reset: W, R, W, R ...
    @(posedge clk); #1;
    rst = 1'b0;
    awaddr = 12'h020; araddr = 12'h021; wdata = 32'h12345678; wstrb = 4'hF;
    bready = 1'b1; rready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (awready && arready) fail("both_ready", "write and read granted together");
      if (awready) begin
        gseq.push_back(1'b1); gcyc.push_back(cyc);
        ref_write(10'd8, 32'h12345678, 4'hF);
        exp_bq.push_back(2'b00);
      end
      if (arready) begin
        gseq.push_back(1'b0); gcyc.push_back(cyc);
        exp_rq.push_back(ref_mem[8]);
      end
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    check("contention_grants", gseq.size(), 32'd12);
    ecyc = 0;
    for (int i = 0; i < gseq.size(); i++) begin
      check("contention_kind", {31'h0, gseq[i]}, {31'h0, (i % 2 == 0)});
      check("contention_cycle", gcyc[i], ecyc);
      ecyc += gseq[i] ? 3 : 4;
    end

    // Directed transactions.
    do_write(12'h010, 32'hAABBCCDD, 4'hF, 0);
    do_read(12'h012, 0);
    do_write(12'h010, 32'h00001100, 4'b0010, 0);
    do_read(12'h010, 2);
    do_write(12'h014, 32'hCAFEF00D, 4'hF, 5);
    do_write(12'h014, 32'h11111111, 4'h0, 1);
    do_read(12'h017, 0);
    half_valid();

    // Randomised mix.
    for (int n = 0; n < 40; n++) begin
      row = rows[$urandom_range(0, 3)];
      a = {row, 2'($urandom_range(0, 3))};
      case ($urandom_range(0, 3))
        0, 1: do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
        2:    do_read(a, $urandom_range(0, 3));
        default: half_valid();
      endcase
    end

    // Reset mid-transaction leaves the bank and response channels untouched.
    abort_write(12'h014, 32'hDEADBEEF);
    do_read(12'h014, 0);
    abort_read(12'h010);
    do_read(12'h010, 1);

    repeat (3) @(negedge clk);
    check("b_queue_drained", exp_bq.size(), 32'd0);
    check("r_queue_drained", exp_rq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_bank_ctrl.md
AXI_BANK_CTRL -- requirements
Module: axi_bank_ctrl

Interface
REQ-001 The module SHALL have parameter SIZE, default 7, meaning log2 of bank row width in bytes (row = 2**SIZE bytes; bank = 4096 bytes, 2**(12-SIZE) rows).
REQ-002 The module SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 awvalid/awready  in/out  1/1  write-address handshake; awaddr  in  12  byte address.
REQ-006 wvalid/wready  in/out  1/1  write-data handshake; wdata  in  2**SIZE x 8  row data; wstrb  in  2**SIZE  byte enables.
REQ-007 bvalid/bready  out/in  1/1  write response; bresp  out  2  always 2'b00 (OKAY).
REQ-008 arvalid/arready  in/out  1/1  read-address handshake; araddr  in  12  byte address.
REQ-009 rvalid/rready  out/in  1/1  read response; rdata  out  2**SIZE x 8; rresp  out  2  always 2'b00.
REQ-010 bank_we  out  1  bank write enable; bank_row_addr  out  12-SIZE  row index; bank_wdata  out  2**SIZE x 8; bank_wstrb  out  2**SIZE  byte enables.
REQ-011 bank_rdata  in  2**SIZE x 8  bank read data, registered in bank, valid one cycle after bank_row_addr is presented.

Function
REQ-012 Single-beat transactions only; one transaction outstanding at a time.
REQ-013 Row index SHALL be addr[11:SIZE]; addr[SIZE-1:0] ignored.
REQ-014 FSM states: IDLE, WR_BANK, WR_RESP, RD_ADDR, RD_CAP, RD_RESP.
REQ-015 IDLE: write pending = awvalid && wvalid; read pending = arvalid; awready/wready SHALL assert only together, combinationally, when a write is granted; arready only when a read is granted.
REQ-016 Both pending: grant opposite of last_grant flag (alternate); last_grant after reset = read, so first contention grants write.
REQ-017 awvalid without wvalid (or vice versa) SHALL NOT be accepted; no ready asserted.
REQ-018 Write grant (cycle T): capture row, wdata, wstrb; next state WR_BANK.
REQ-019 WR_BANK (T+1): bank_we=1, bank_wstrb=captured strobe, bank_wdata/bank_row_addr=captured; next WR_RESP.
REQ-020 WR_RESP (T+2 onward): bvalid=1 until bvalid && bready; then IDLE; bvalid SHALL remain stable while bready low.
REQ-021 Read grant (cycle T): capture row; next RD_ADDR.
REQ-022 RD_ADDR (T+1): bank_row_addr=captured row; next RD_CAP.
REQ-023 RD_CAP (T+2): register bank_rdata into rdata; next RD_RESP.
REQ-024 RD_RESP (T+3 onward): rvalid=1, rdata held stable until rvalid && rready; then IDLE.
REQ-025 Outside WR_BANK, bank_we SHALL be 0 and bank_wstrb SHALL be all-zero (bank writes on strobe alone).
REQ-026 Write with wstrb=0 SHALL complete normally (B response issued, bank unchanged).
REQ-027 Read after write to same row SHALL return new data (write completes in bank before B issued).
REQ-028 New requests SHALL not be accepted in any non-IDLE state; earliest next grant is the cycle after the B/R handshake.

Reset
REQ-029 While rst=1: state IDLE, awready=wready=arready=0, bvalid=rvalid=0, bank_we=0, bank_wstrb=0, rdata=0, bank_row_addr=0, last_grant=read.
REQ-030 Reset in any state SHALL abandon the transaction without a bank write or response; first grant possible the cycle after rst deasserts.

Verification
REQ-031 SIZE=2: write awaddr=0x010, wdata=0xAABBCCDD, wstrb=4'hF -> bank_we=1 row=4 one cycle after handshake; bvalid next cycle, bresp=00.
REQ-032 SIZE=2: read araddr=0x012 after REQ-031 -> rvalid 3 cycles after AR handshake, rdata=0xAABBCCDD, rresp=00.
REQ-033 Partial write wstrb=4'b0010, wdata=0x00001100 to row 4 -> subsequent read returns 0xAABB11DD.
REQ-034 awvalid, wvalid, arvalid asserted same cycle from reset -> write granted first; read granted in next IDLE; alternation repeats under continuous contention.
REQ-035 bready held low 5 cycles -> bvalid stays 1, no ready asserted, bank_wstrb=0 throughout; completes on bready.
REQ-036 rst asserted in WR_BANK-preceding cycle (WR_BANK never entered) -> no bank write, no bvalid; read of row returns old data.
